// File: rtl/id_ex_stage_pkg.sv
// Shared ALU opcodes, operand-select encodings and the ID/EX pipeline register layout.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [3:0] EXE_ALU_ADD = 4'd0;
  localparam logic [3:0] EXE_ALU_SUB = 4'd1;
  localparam logic [3:0] EXE_ALU_AND = 4'd2;
  localparam logic [3:0] EXE_ALU_OR  = 4'd3;
  localparam logic [3:0] EXE_ALU_XOR = 4'd4;
  localparam logic [3:0] EXE_ALU_NOR = 4'd5;
  localparam logic [3:0] EXE_ALU_SLT = 4'd6;
  localparam logic [3:0] EXE_ALU_SLL = 4'd7;
  localparam logic [3:0] EXE_ALU_SRL = 4'd8;
  localparam logic [3:0] EXE_ALU_SRA = 4'd9;
  localparam logic [3:0] EXE_ALU_LUI = 4'd10;

  localparam logic [1:0] A_SEL_RS    = 2'd0;
  localparam logic [1:0] A_SEL_SHAMT = 2'd1;
  localparam logic [1:0] A_SEL_RSLO  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        oper;
    logic              sign;
    logic [DATA_W-1:0] store_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic              mem_ren;
    logic              mem_wen;
  } ex_reg_t;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic sext);
    return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way priority forwarding mux: EX/MEM, then MEM/WB, then regfile; register 0 never forwards.
// Purely combinational, no backpressure.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_en && (mem_addr == src_addr) && (src_addr != '0);
  assign wb_hit  = wb_en  && (wb_addr  == src_addr) && (src_addr != '0);

  always_comb begin
    fwd_data = rf_data;
    if (mem_hit)     fwd_data = mem_data;
    else if (wb_hit) fwd_data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX stage: forwards and selects ALU operands, registers them 1 cycle ahead of the ALU.
// Holds on ex_stall, inserts one bubble per load-use hazard, flush wins over stall.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [ADDR_W-1:0]      id_rs_addr,
  input  logic [ADDR_W-1:0]      id_rt_addr,
  input  logic [DATA_W-1:0]      id_rs_data,
  input  logic [DATA_W-1:0]      id_rt_data,
  input  logic [15:0]            id_imm,
  input  logic [4:0]             id_shamt,
  input  logic                   id_imm_sext,
  input  logic [1:0]             id_a_sel,
  input  logic                   id_b_imm,
  input  logic [3:0]             id_alu_oper,
  input  logic                   id_alu_sign,
  input  logic                   id_wb_en,
  input  logic [ADDR_W-1:0]      id_wb_addr,
  input  logic                   id_mem_ren,
  input  logic                   id_mem_wen,
  input  logic                   mem_wb_en,
  input  logic [ADDR_W-1:0]      mem_wb_addr,
  input  logic [DATA_W-1:0]      mem_fwd_data,
  input  logic                   wb_wb_en,
  input  logic [ADDR_W-1:0]      wb_wb_addr,
  input  logic [DATA_W-1:0]      wb_fwd_data,
  input  logic                   ex_stall,
  input  logic                   flush,
  output logic                   id_stall,
  output logic                   ex_valid,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [3:0]             alu_oper,
  output logic                   alu_sign,
  output logic [DATA_W-1:0]      ex_store_data,
  output logic                   ex_wb_en,
  output logic [ADDR_W-1:0]      ex_wb_addr,
  output logic                   ex_mem_ren,
  output logic                   ex_mem_wen,
  output logic [STALL_CNT_W-1:0] bubble_cnt
);

  ex_reg_t           ex_q;
  ex_reg_t           cap;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic              hazard;

  fwd_mux u_fwd_rs (
    .src_addr (id_rs_addr),
    .rf_data  (id_rs_data),
    .mem_en   (mem_wb_en),
    .mem_addr (mem_wb_addr),
    .mem_data (mem_fwd_data),
    .wb_en    (wb_wb_en),
    .wb_addr  (wb_wb_addr),
    .wb_data  (wb_fwd_data),
    .fwd_data (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .src_addr (id_rt_addr),
    .rf_data  (id_rt_data),
    .mem_en   (mem_wb_en),
    .mem_addr (mem_wb_addr),
    .mem_data (mem_fwd_data),
    .wb_en    (wb_wb_en),
    .wb_addr  (wb_wb_addr),
    .wb_data  (wb_fwd_data),
    .fwd_data (rt_fwd)
  );

  // A load in EX has no data yet; a dependent ID instruction must wait one cycle.
  assign hazard = id_valid && ex_q.valid && ex_q.mem_ren && ex_q.wb_en && (ex_q.wb_addr != '0) &&
                  ((ex_q.wb_addr == id_rs_addr) || (ex_q.wb_addr == id_rt_addr));
  assign id_stall = ex_stall || hazard;

  always_comb begin
    cap            = '0;
    cap.valid      = id_valid;
    cap.b          = id_b_imm ? ext_imm(id_imm, id_imm_sext) : rt_fwd;
    cap.oper       = id_alu_oper;
    cap.sign       = id_alu_sign;
    cap.store_data = rt_fwd;
    cap.wb_en      = id_valid && id_wb_en;
    cap.wb_addr    = id_wb_addr;
    cap.mem_ren    = id_valid && id_mem_ren;
    cap.mem_wen    = id_valid && id_mem_wen;
    case (id_a_sel)
      A_SEL_RS:    cap.a = rs_fwd;
      A_SEL_SHAMT: cap.a = {{(DATA_W-5){1'b0}}, id_shamt};
      A_SEL_RSLO:  cap.a = {{(DATA_W-5){1'b0}}, rs_fwd[4:0]};
      default:     cap.a = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      ex_q.valid   <= 1'b0;
      ex_q.wb_en   <= 1'b0;
      ex_q.mem_ren <= 1'b0;
      ex_q.mem_wen <= 1'b0;
    end else if (!ex_stall) begin
      if (hazard) begin
        ex_q.valid   <= 1'b0;
        ex_q.wb_en   <= 1'b0;
        ex_q.mem_ren <= 1'b0;
        ex_q.mem_wen <= 1'b0;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
      end else begin
        ex_q <= cap;
      end
    end
  end

  assign ex_valid      = ex_q.valid;
  assign alu_a         = ex_q.a;
  assign alu_b         = ex_q.b;
  assign alu_oper      = ex_q.oper;
  assign alu_sign      = ex_q.sign;
  assign ex_store_data = ex_q.store_data;
  assign ex_wb_en      = ex_q.wb_en;
  assign ex_wb_addr    = ex_q.wb_addr;
  assign ex_mem_ren    = ex_q.mem_ren;
  assign ex_mem_wen    = ex_q.mem_wen;

endmodule
